// File: rtl/score_counter.sv
// score_counter: 8-bit game score with press/hold auto-repeat,
// collision freeze, session high score and restart.
module score_counter #(
   parameter int HOLD_FRAMES = 8,
   parameter int SCORE_MAX   = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_frame_tick,
   input  logic       i_move,
   input  logic       i_collision,
   input  logic       i_restart,
   output logic [7:0] o_score,
   output logic [7:0] o_high_score,
   output logic       o_game_over,
   output logic       o_score_pulse
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HELD = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [7:0] LP_MAX  = 8'(SCORE_MAX);
   localparam logic [7:0] LP_LAST = 8'(HOLD_FRAMES - 1);

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_sync1;
   logic       r_sync2;
   logic       r_move_prev;

   logic [7:0] r_frame_cnt;
   logic [7:0] w_frame_cnt_nxt;
   logic [7:0] r_score;
   logic [7:0] w_score_nxt;
   logic [7:0] r_high;
   logic [7:0] w_high_nxt;
   logic       r_pulse;
   logic       w_pulse_nxt;

   logic       w_move_s;
   logic       w_press;
   logic       w_can_inc;
   logic [7:0] w_score_inc;
   logic [7:0] w_high_cand;

   assign w_move_s    = r_sync2;
   assign w_press     = w_move_s & ~r_move_prev;
   assign w_can_inc   = (r_score < LP_MAX);
   assign w_score_inc = r_score + 8'd1;
   assign w_high_cand = (r_score > r_high) ? r_score : r_high;

   // i_move is asynchronous to i_clk
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_move_prev <= 1'b0;
      end else begin
         r_sync1     <= i_move;
         r_sync2     <= r_sync1;
         r_move_prev <= r_sync2;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_frame_cnt <= 8'd0;
         r_score     <= 8'd0;
         r_high      <= 8'd0;
         r_pulse     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_score     <= w_score_nxt;
         r_high      <= w_high_nxt;
         r_pulse     <= w_pulse_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_frame_cnt_nxt = r_frame_cnt;
      w_score_nxt     = r_score;
      w_high_nxt      = r_high;
      w_pulse_nxt     = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (i_restart) begin
               w_score_nxt     = 8'd0;
               w_frame_cnt_nxt = 8'd0;
            end else if (i_collision) begin
               w_state_nxt = S_OVER;
               w_high_nxt  = w_high_cand;
            end else if (w_press) begin
               w_state_nxt     = S_HELD;
               w_frame_cnt_nxt = 8'd0;
               if (w_can_inc) begin
                  w_score_nxt = w_score_inc;
                  w_pulse_nxt = 1'b1;
               end
            end
         end

         S_HELD: begin
            if (i_restart) begin
               w_state_nxt     = S_IDLE;
               w_score_nxt     = 8'd0;
               w_frame_cnt_nxt = 8'd0;
            end else if (i_collision) begin
               w_state_nxt = S_OVER;
               w_high_nxt  = w_high_cand;
            end else if (!w_move_s) begin
               w_state_nxt     = S_IDLE;
               w_frame_cnt_nxt = 8'd0;
            end else if (i_frame_tick) begin
               if (r_frame_cnt == LP_LAST) begin
                  w_frame_cnt_nxt = 8'd0;
                  if (w_can_inc) begin
                     w_score_nxt = w_score_inc;
                     w_pulse_nxt = 1'b1;
                  end
               end else begin
                  w_frame_cnt_nxt = r_frame_cnt + 8'd1;
               end
            end
         end

         S_OVER: begin
            if (i_restart) begin
               w_state_nxt     = S_IDLE;
               w_score_nxt     = 8'd0;
               w_frame_cnt_nxt = 8'd0;
            end
         end

         default: begin
            w_state_nxt     = S_IDLE;
            w_frame_cnt_nxt = 8'd0;
         end
      endcase
   end

   assign o_score       = r_score;
   assign o_high_score  = r_high;
   assign o_game_over   = (r_state == S_OVER);
   assign o_score_pulse = r_pulse;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed stimulus, cycle-level behavioural
// model with per-cycle compare, plus literal spot checks.
module tb_score_counter;

   localparam int HOLD = 8;
   localparam int SMAX = 255;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_frame_tick;
   logic       i_move;
   logic       i_collision;
   logic       i_restart;
   logic [7:0] o_score;
   logic [7:0] o_high_score;
   logic       o_game_over;
   logic       o_score_pulse;

   score_counter #(
      .HOLD_FRAMES(HOLD),
      .SCORE_MAX  (SMAX)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_frame_tick (i_frame_tick),
      .i_move       (i_move),
      .i_collision  (i_collision),
      .i_restart    (i_restart),
      .o_score      (o_score),
      .o_high_score (o_high_score),
      .o_game_over  (o_game_over),
      .o_score_pulse(o_score_pulse)
   );

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the button as seen after a 2-cycle delay, a hold run
   // counted in ticks since the press, and a game-over flag.
   logic [2:0] m_hist = 3'b000;
   int  m_score = 0;
   int  m_high = 0;
   int  m_ticks = 0;
   bit  m_holding = 0;
   bit  m_over = 0;
   bit  m_pulse = 0;

   task automatic bump();
      if (m_score < SMAX) begin
         m_score = m_score + 1;
         m_pulse = 1;
      end
   endtask

   task automatic model_step();
      bit ms;
      bit mp;
      ms = m_hist[1];
      mp = m_hist[2];
      m_pulse = 0;
      if (i_restart) begin
         m_score = 0;
         m_holding = 0;
         m_over = 0;
      end else if (m_over) begin
         m_over = 1;
      end else if (i_collision) begin
         m_over = 1;
         m_holding = 0;
         if (m_score > m_high) m_high = m_score;
      end else if (!m_holding) begin
         if (ms && !mp) begin
            bump();
            m_holding = 1;
            m_ticks = 0;
         end
      end else if (!ms) begin
         m_holding = 0;
      end else if (i_frame_tick) begin
         m_ticks = m_ticks + 1;
         if (m_ticks % HOLD == 0) bump();
      end
      m_hist = {m_hist[1:0], i_move};
   endtask

   task automatic model_reset();
      m_hist = 3'b000;
      m_score = 0;
      m_high = 0;
      m_ticks = 0;
      m_holding = 0;
      m_over = 0;
      m_pulse = 0;
   endtask

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) model_reset();
      else model_step();
   end

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         chk("score", int'(o_score), m_score);
         chk("high", int'(o_high_score), m_high);
         chk("game_over", int'(o_game_over), int'(m_over));
         chk("pulse", int'(o_score_pulse), int'(m_pulse));
         if (o_score_pulse) pulse_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      i_frame_tick = 1'b1;
      cyc(n);
      i_frame_tick = 1'b0;
   endtask

   task automatic restart();
      i_restart = 1'b1;
      cyc(1);
      i_restart = 1'b0;
   endtask

   int p0;

   initial begin
      i_rst_n      = 1'b0;
      i_frame_tick = 1'b0;
      i_move       = 1'b0;
      i_collision  = 1'b0;
      i_restart    = 1'b0;
      #12;
      chk("rst_score", int'(o_score), 0);
      chk("rst_high", int'(o_high_score), 0);
      chk("rst_go", int'(o_game_over), 0);
      chk("rst_pulse", int'(o_score_pulse), 0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      cyc(2);

      // Single press: 3-cycle latency
      p0 = pulse_cnt;
      i_move = 1'b1;
      cyc(2);
      chk("lat_before", int'(o_score), 0);
      cyc(1);
      chk("lat_score", int'(o_score), 1);
      chk("lat_pulse", int'(o_score_pulse), 1);
      i_move = 1'b0;
      cyc(4);
      chk("tap_score", int'(o_score), 1);
      chk("tap_pulses", pulse_cnt - p0, 1);

      // Hold across 24 ticks
      restart();
      chk("rs_score", int'(o_score), 0);
      p0 = pulse_cnt;
      i_move = 1'b1;
      cyc(4);
      ticks(24);
      i_move = 1'b0;
      cyc(4);
      chk("hold24_score", int'(o_score), 4);
      chk("hold24_pulses", pulse_cnt - p0, 4);

      // Climb to 254, then saturate
      restart();
      i_move = 1'b1;
      cyc(4);
      ticks(253 * HOLD);
      i_move = 1'b0;
      cyc(4);
      chk("climb254", int'(o_score), 254);
      p0 = pulse_cnt;
      i_move = 1'b1;
      cyc(4);
      ticks(16);
      i_move = 1'b0;
      cyc(4);
      chk("sat_score", int'(o_score), 255);
      chk("sat_pulses", pulse_cnt - p0, 1);

      // Collision on the 8th held tick at score 37
      restart();
      i_move = 1'b1;
      cyc(4);
      ticks(36 * HOLD);
      chk("climb37", int'(o_score), 37);
      ticks(HOLD - 1);
      i_frame_tick = 1'b1;
      i_collision  = 1'b1;
      cyc(1);
      i_frame_tick = 1'b0;
      i_collision  = 1'b0;
      chk("col_score", int'(o_score), 37);
      chk("col_go", int'(o_game_over), 1);
      chk("col_high", int'(o_high_score), 37);
      i_move = 1'b0;
      cyc(4);
      i_move = 1'b1;
      cyc(4);
      ticks(16);
      i_move = 1'b0;
      cyc(4);
      chk("over_frozen", int'(o_score), 37);
      chk("over_go", int'(o_game_over), 1);

      // Restart from game over with the button held
      i_move = 1'b1;
      cyc(4);
      restart();
      chk("rso_score", int'(o_score), 0);
      chk("rso_go", int'(o_game_over), 0);
      chk("rso_high", int'(o_high_score), 37);
      ticks(16);
      cyc(2);
      chk("held_no_inc", int'(o_score), 0);
      i_move = 1'b0;
      cyc(4);
      i_move = 1'b1;
      cyc(4);
      chk("repress", int'(o_score), 1);
      i_move = 1'b0;
      cyc(4);

      // Async reset mid-hold at score 12
      restart();
      i_move = 1'b1;
      cyc(4);
      ticks(11 * HOLD);
      chk("climb12", int'(o_score), 12);
      @(posedge i_clk);
      #3 i_rst_n = 1'b0;
      #1;
      chk("arst_score", int'(o_score), 0);
      chk("arst_high", int'(o_high_score), 0);
      chk("arst_go", int'(o_game_over), 0);
      chk("arst_pulse", int'(o_score_pulse), 0);
      i_move = 1'b0;
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      cyc(3);
      chk("post_score", int'(o_score), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Upstream stage of the score renderer; produces the 8-bit binary score that the renderer displays as three digits.
- Score increments while the player holds the move button: one immediate step on press, then one step every HOLD_FRAMES frames while held.
- Freezes on collision (game over), tracks a session high score, and clears on restart.

Parameters:
HOLD_FRAMES, 8, frame ticks between auto-increments while move is held (legal range 1..255)
SCORE_MAX, 255, saturation ceiling for o_score (must be <= 255)

Ports:
i_clk  input  1  system/pixel clock
i_rst_n  input  1  asynchronous active-low reset
i_frame_tick  input  1  single-cycle pulse once per frame (end of active video)
i_move  input  1  raw move button, asynchronous to i_clk
i_collision  input  1  single-cycle pulse: player hit an obstacle
i_restart  input  1  single-cycle pulse: start a new game
o_score  output  8  current score, binary, registered
o_high_score  output  8  highest score reached since reset, registered
o_game_over  output  1  high while in S_OVER
o_score_pulse  output  1  one-cycle pulse on every accepted increment

Behaviour:
- Reset (async, i_rst_n=0): o_score=0, o_high_score=0, o_game_over=0, o_score_pulse=0, state=S_IDLE, frame counter=0, sync flops=0, move_prev=0.
- i_move passes through a 2-flop synchronizer -> move_s. move_prev is move_s delayed one cycle. press = move_s & ~move_prev.
- Increment = o_score+1 if o_score<SCORE_MAX; else no change and no o_score_pulse. No wrap.
- o_score and o_score_pulse update on the same clock edge as the increment decision. Latency from i_move edge to o_score change is 3 cycles: 2 sync + 1 register.
- Frame counter is 8 bits and advances only in S_HELD on i_frame_tick.
- S_IDLE:
  - press: increment, frame counter=0, go S_HELD.
  - i_collision: go S_OVER. Takes priority over a same-cycle press; no increment.
- S_HELD:
  - move_s=0: go S_IDLE; frame counter=0.
  - i_frame_tick while held: if counter==HOLD_FRAMES-1, increment and counter=0; else counter+1.
  - i_collision: go S_OVER. Takes priority over a same-cycle tick-driven increment.
- S_OVER:
  - o_game_over=1.
  - On entry cycle, o_high_score <= max(o_high_score, o_score).
  - Score is frozen; press, i_frame_tick and i_collision are ignored.
  - i_restart: o_score=0, counter=0, go S_IDLE.
- i_restart in S_IDLE or S_HELD: o_score=0, counter=0, go S_IDLE. High score is unchanged. A same-cycle i_collision loses to restart.
- Restart with the button still held: move_prev=1, so no press is generated. The player must release and press again before the next increment.
- i_frame_tick coincident with a press in S_IDLE: press handled; tick ignored because counter starts at 0 in S_HELD.
- Mid-operation async reset returns everything to reset values immediately. o_high_score is also cleared.

Test Plan:
- Reset, then pulse i_move high for 1 frame with no ticks -> o_score=1 exactly 3 cycles after the edge; one o_score_pulse; state S_IDLE after release.
- Hold i_move across 24 frame ticks, HOLD_FRAMES=8 -> o_score=4 (1 press + 3 repeats); 4 o_score_pulses total.
- Preload score to 254, SCORE_MAX=255, hold across 16 ticks -> o_score=255; only 1 pulse; no wrap to 0.
- Score=37, i_collision coincident with the 8th held tick -> o_score stays 37, o_game_over=1, o_high_score=37 next cycle. Further presses do not change the score.
- In S_OVER with score 37, pulse i_restart while i_move held -> o_score=0, o_game_over=0, o_high_score=37. No increment until release and re-press, then o_score=1.
- Assert i_rst_n=0 asynchronously mid-hold with score 12 -> all outputs 0 without waiting for a clock edge.
